// File: rtl/timer_sched.sv
// timer_sched : four-slot deadline scheduler driving a single 64-bit hardware
// compare timer through a small register master port.
//
// Optional feature: define TSCHED_PERIODIC_EN to add per-slot reload periods.
// When it is defined, an expiring slot with a nonzero period moves its
// deadline forward by the period and stays armed. Without it, every slot is
// one-shot and cfg_period is ignored.
//
// Ports
//   clk, rst_n          system clock, synchronous active-low reset
//   cfg_valid/ready     arm/cancel handshake (ready only while IDLE or POLL)
//   cfg_op              1 = arm, 0 = cancel
//   cfg_slot            slot index 0..3
//   cfg_deadline        64-bit absolute deadline for arm
//   cfg_period          64-bit reload period (periodic build only)
//   pend, pend_clr      per-slot expired flags, write-1-clear
//   irq                 OR of pend
//   t_en/t_we/t_re      timer master strobes
//   t_addr, t_wdata     2 = cmp_lo, 3 = cmp_hi, 4 = flag
//   t_rdata             combinational read data, bit 0 = compare flag
module timer_sched #(
   parameter logic [63:0] IDLE_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic        cfg_op,
   input  logic [1:0]  cfg_slot,
   input  logic [63:0] cfg_deadline,
   input  logic [63:0] cfg_period,
   output logic [3:0]  pend,
   input  logic [3:0]  pend_clr,
   output logic        irq,
   output logic        t_en,
   output logic        t_we,
   output logic        t_re,
   output logic [2:0]  t_addr,
   output logic [31:0] t_wdata,
   input  logic [31:0] t_rdata
);

   typedef enum logic [2:0] {
      IDLE, SCAN, WR_LO_MAX, WR_HI, WR_LO, SETTLE, POLL, EXPIRE
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  armed;
   logic [63:0] deadline [4];
   logic [63:0] tgt;
   logic [63:0] scan_min;
   logic        scan_found;
   logic [3:0]  hit;
   logic        xfer;

`ifdef TSCHED_PERIODIC_EN
   logic [63:0] period [4];
   logic        unused_inputs;
   assign unused_inputs = ^t_rdata[31:1];
`else
   logic        unused_inputs;
   assign unused_inputs = ^{cfg_period, t_rdata[31:1]};
`endif

   assign xfer = cfg_valid && cfg_ready;
   assign irq  = |pend;

   // Earliest armed deadline (strict less-than keeps the lowest index on a
   // tie), the set of slots matching the programmed target, and the next
   // state. A config transfer in POLL beats a simultaneous timer flag so a
   // fresh arm/cancel is never lost behind an expiry.
   always_comb begin
      scan_min   = IDLE_CMP;
      scan_found = 1'b0;
      hit        = 4'b0000;
      state_nxt  = state;
      for (int i = 0; i < 4; i++) begin
         if (armed[i] && (!scan_found || deadline[i] < scan_min)) begin
            scan_min   = deadline[i];
            scan_found = 1'b1;
         end
         hit[i] = armed[i] && (deadline[i] == tgt);
      end
      case (state)
         IDLE:      if (xfer) state_nxt = SCAN;
         SCAN:      state_nxt = WR_LO_MAX;
         WR_LO_MAX: state_nxt = WR_HI;
         WR_HI:     state_nxt = WR_LO;
         WR_LO:     state_nxt = SETTLE;
         SETTLE:    state_nxt = (|armed) ? POLL : IDLE;
         POLL: begin
            if (xfer)            state_nxt = SCAN;
            else if (t_rdata[0]) state_nxt = EXPIRE;
         end
         EXPIRE:    state_nxt = SCAN;
         default:   state_nxt = IDLE;
      endcase
   end

   // All state lives here. Timer-port outputs are registered from the state
   // being entered, so each strobe is valid for exactly the cycle spent in
   // that state. Low word goes to all-ones first so the comparator never sees
   // a half-updated value that lies earlier than the intended target.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         armed     <= 4'b0000;
         pend      <= 4'b0000;
         tgt       <= IDLE_CMP;
         cfg_ready <= 1'b1;
         t_en      <= 1'b0;
         t_we      <= 1'b0;
         t_re      <= 1'b0;
         t_addr    <= 3'd0;
         t_wdata   <= 32'd0;
         for (int i = 0; i < 4; i++) begin
            deadline[i] <= 64'd0;
`ifdef TSCHED_PERIODIC_EN
            period[i]   <= 64'd0;
`endif
         end
      end else begin
         state     <= state_nxt;
         cfg_ready <= (state_nxt == IDLE) || (state_nxt == POLL);
         t_en      <= 1'b0;
         t_we      <= 1'b0;
         t_re      <= 1'b0;
         t_addr    <= 3'd0;
         t_wdata   <= 32'd0;
         case (state_nxt)
            WR_LO_MAX: begin
               t_en <= 1'b1; t_we <= 1'b1; t_addr <= 3'd2; t_wdata <= 32'hFFFF_FFFF;
            end
            WR_HI: begin
               t_en <= 1'b1; t_we <= 1'b1; t_addr <= 3'd3; t_wdata <= tgt[63:32];
            end
            WR_LO: begin
               t_en <= 1'b1; t_we <= 1'b1; t_addr <= 3'd2; t_wdata <= tgt[31:0];
            end
            POLL: begin
               t_en <= 1'b1; t_re <= 1'b1; t_addr <= 3'd4;
            end
            default: ;
         endcase

         if (xfer) begin
            armed[cfg_slot] <= cfg_op;
            if (cfg_op) begin
               deadline[cfg_slot] <= cfg_deadline;
`ifdef TSCHED_PERIODIC_EN
               period[cfg_slot]   <= cfg_period;
`endif
            end
         end

         if (state == SCAN) tgt <= scan_min;

         // A set from EXPIRE wins over a clear landing on the same bit.
         pend <= (pend & ~pend_clr) | ((state == EXPIRE) ? hit : 4'b0000);

         if (state == EXPIRE) begin
            for (int i = 0; i < 4; i++) begin
               if (hit[i]) begin
`ifdef TSCHED_PERIODIC_EN
                  if (period[i] != 64'd0) deadline[i] <= deadline[i] + period[i];
                  else                    armed[i]    <= 1'b0;
`else
                  armed[i] <= 1'b0;
`endif
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched : directed bench for timer_sched. A small timer model logs
// every compare write and raises its flag on request; the flag drops one
// edge after any compare write, as the real timer does.
module tb_timer_sched;

   localparam logic [63:0] IDLE_CMP = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic        cfg_op = 1'b0;
   logic [1:0]  cfg_slot = 2'd0;
   logic [63:0] cfg_deadline = 64'd0;
   logic [63:0] cfg_period = 64'd0;
   logic [3:0]  pend;
   logic [3:0]  pend_clr = 4'b0000;
   logic        irq;
   logic        t_en, t_we, t_re;
   logic [2:0]  t_addr;
   logic [31:0] t_wdata;
   logic [31:0] t_rdata;

   int total = 0;
   int bad = 0;

   logic        flag = 1'b0;
   logic        fire = 1'b0;
   logic [34:0] wr_q [$];

   typedef struct {
      logic [1:0]  slot;
      logic [63:0] deadline;
      logic [3:0]  exp_pend;
   } vec_t;
   vec_t vecs [4];

   timer_sched #(.IDLE_CMP(IDLE_CMP)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op),
      .cfg_slot(cfg_slot), .cfg_deadline(cfg_deadline), .cfg_period(cfg_period),
      .pend(pend), .pend_clr(pend_clr), .irq(irq),
      .t_en(t_en), .t_we(t_we), .t_re(t_re), .t_addr(t_addr),
      .t_wdata(t_wdata), .t_rdata(t_rdata)
   );

   always #5 clk = ~clk;

   // Timer model: capture writes, keep the compare flag.
   assign t_rdata = {31'd0, flag};
   always @(posedge clk) begin
      if (t_en && t_we) begin
         wr_q.push_back({t_addr, t_wdata});
         flag <= 1'b0;
      end else if (fire) begin
         flag <= 1'b1;
      end
   end

   // Hard stop in case something wedges outside a bounded wait.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic op, input logic [1:0] slot,
                                input logic [63:0] dl, input logic [63:0] per);
      bit ok = 1'b0;
      cfg_valid = 1'b1; cfg_op = op; cfg_slot = slot;
      cfg_deadline = dl; cfg_period = per;
      for (int n = 0; n < 50; n++) begin
         if (cfg_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      checkOutput("cfg handshake", {63'd0, ok}, 64'd1);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic waitPoll(input string name);
      bit ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         if (cfg_ready && t_en && t_re && t_addr == 3'd4) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      checkOutput(name, {63'd0, ok}, 64'd1);
   endtask

   task automatic waitIdle(input string name);
      bit ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         if (cfg_ready && !t_en) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      checkOutput(name, {63'd0, ok}, 64'd1);
   endtask

   // Raise the flag for one edge; returns in the EXPIRE cycle.
   task automatic fireTimer();
      fire = 1'b1;
      @(negedge clk);
      fire = 1'b0;
      @(negedge clk);
   endtask

   task automatic clearPend();
      pend_clr = 4'hF;
      @(negedge clk);
      pend_clr = 4'h0;
   endtask

   // Expect exactly the glitch-free triple for target value tgt.
   task automatic checkSeq(input string name, input logic [63:0] tgt);
      logic [34:0] exp [3];
      logic [34:0] got;
      exp[0] = {3'd2, 32'hFFFF_FFFF};
      exp[1] = {3'd3, tgt[63:32]};
      exp[2] = {3'd2, tgt[31:0]};
      checkOutput({name, " count"}, 64'(wr_q.size()), 64'd3);
      for (int i = 0; i < 3; i++) begin
         got = (i < wr_q.size()) ? wr_q[i] : 35'd0;
         checkOutput($sformatf("%s wr%0d", name, i), {29'd0, got}, {29'd0, exp[i]});
      end
      wr_q.delete();
   endtask

   task automatic checkResetOutputs(input string name);
      checkOutput({name, " cfg_ready"}, {63'd0, cfg_ready}, 64'd1);
      checkOutput({name, " irq"}, {63'd0, irq}, 64'd0);
      checkOutput({name, " pend"}, {60'd0, pend}, 64'd0);
      checkOutput({name, " tport"}, {25'd0, t_en, t_we, t_re, t_addr, t_wdata}, 64'd0);
   endtask

   initial begin
      int en_cnt, pend_cnt, irq_cnt, nrdy_cnt;

      vecs[0] = '{slot: 2'd1, deadline: 64'h0000_0001_0000_0010, exp_pend: 4'b0010};
      vecs[1] = '{slot: 2'd0, deadline: 64'h0000_0000_0000_0000, exp_pend: 4'b0001};
      vecs[2] = '{slot: 2'd3, deadline: 64'hFFFF_FFFF_0000_0000, exp_pend: 4'b1000};
      vecs[3] = '{slot: 2'd2, deadline: 64'h0000_0000_FFFF_FFFF, exp_pend: 4'b0100};

      // Reset, then 100 quiet cycles.
      repeat (3) @(negedge clk);
      checkResetOutputs("in reset");
      rst_n = 1'b1;
      en_cnt = 0; pend_cnt = 0; irq_cnt = 0; nrdy_cnt = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (t_en) en_cnt++;
         if (pend != 4'b0) pend_cnt++;
         if (irq) irq_cnt++;
         if (!cfg_ready) nrdy_cnt++;
      end
      checkOutput("quiet t_en cycles", 64'(en_cnt), 64'd0);
      checkOutput("quiet pend cycles", 64'(pend_cnt), 64'd0);
      checkOutput("quiet irq cycles", 64'(irq_cnt), 64'd0);
      checkOutput("quiet not-ready cycles", 64'(nrdy_cnt), 64'd0);
      checkOutput("quiet writes", 64'(wr_q.size()), 64'd0);

      // Single-slot arm / expire vectors.
      for (int v = 0; v < 4; v++) begin
         clearPend();
         wr_q.delete();
         applyStimulus(1'b1, vecs[v].slot, vecs[v].deadline, 64'd0);
         waitPoll($sformatf("vec%0d poll", v));
         checkSeq($sformatf("vec%0d arm", v), vecs[v].deadline);
         checkOutput($sformatf("vec%0d pend before", v), {60'd0, pend}, 64'd0);
         fireTimer();
         waitIdle($sformatf("vec%0d idle", v));
         checkOutput($sformatf("vec%0d pend", v), {60'd0, pend}, {60'd0, vecs[v].exp_pend});
         checkOutput($sformatf("vec%0d irq", v), {63'd0, irq}, 64'd1);
         checkSeq($sformatf("vec%0d idlecmp", v), IDLE_CMP);
      end

      // Two slots: earliest first, then the later one.
      clearPend();
      wr_q.delete();
      applyStimulus(1'b1, 2'd0, 64'd500, 64'd0);
      waitPoll("two poll0");
      checkSeq("two 500a", 64'd500);
      applyStimulus(1'b1, 2'd2, 64'd200, 64'd0);
      waitPoll("two poll1");
      checkSeq("two 200", 64'd200);
      fireTimer();
      waitPoll("two poll2");
      checkOutput("two pend1", {60'd0, pend}, 64'b0100);
      checkSeq("two 500b", 64'd500);
      fireTimer();
      waitIdle("two idle");
      checkOutput("two pend2", {60'd0, pend}, 64'b0101);
      checkSeq("two idlecmp", IDLE_CMP);

      // Cancel while polling.
      clearPend();
      wr_q.delete();
      applyStimulus(1'b1, 2'd3, 64'd300, 64'd0);
      waitPoll("cancel poll");
      checkSeq("cancel 300", 64'd300);
      applyStimulus(1'b0, 2'd3, 64'd0, 64'd0);
      waitIdle("cancel idle");
      checkSeq("cancel idlecmp", IDLE_CMP);
      checkOutput("cancel pend", {60'd0, pend}, 64'd0);

      // Clear colliding with a set on the same bit.
      clearPend();
      wr_q.delete();
      applyStimulus(1'b1, 2'd1, 64'd77, 64'd0);
      waitPoll("coll poll0");
      fireTimer();
      waitIdle("coll idle0");
      checkOutput("coll pend0", {60'd0, pend}, 64'b0010);
      applyStimulus(1'b1, 2'd1, 64'd88, 64'd0);
      waitPoll("coll poll1");
      fireTimer();
      pend_clr = 4'b0010;
      @(negedge clk);
      checkOutput("coll set-wins", {60'd0, pend}, 64'b0010);
      @(negedge clk);
      pend_clr = 4'b0000;
      checkOutput("coll cleared", {60'd0, pend}, 64'd0);
      checkOutput("coll irq", {63'd0, irq}, 64'd0);
      waitIdle("coll idle1");
      wr_q.delete();

      // Periodic reload (or one-shot in the default build).
      clearPend();
      wr_q.delete();
      applyStimulus(1'b1, 2'd0, 64'd1000, 64'd250);
      waitPoll("per poll0");
      checkSeq("per 1000", 64'd1000);
      fireTimer();
`ifdef TSCHED_PERIODIC_EN
      waitPoll("per poll1");
      checkSeq("per 1250", 64'd1250);
      checkOutput("per pend", {60'd0, pend}, 64'b0001);
      fireTimer();
      waitPoll("per poll2");
      checkSeq("per 1500", 64'd1500);
      applyStimulus(1'b0, 2'd0, 64'd0, 64'd0);
      waitIdle("per idle");
      checkSeq("per idlecmp", IDLE_CMP);
`else
      waitIdle("oneshot idle");
      checkSeq("oneshot idlecmp", IDLE_CMP);
      checkOutput("oneshot pend", {60'd0, pend}, 64'b0001);
`endif

      // Reset in the middle of a write sequence.
      applyStimulus(1'b1, 2'd2, 64'd5, 64'd0);
      @(negedge clk);
      checkOutput("midrst writing", {63'd0, t_we}, 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      checkResetOutputs("midrst");
      rst_n = 1'b1;
      wr_q.delete();
      repeat (20) @(negedge clk);
      checkOutput("midrst no writes", 64'(wr_q.size()), 64'd0);
      applyStimulus(1'b1, 2'd0, 64'd900, 64'd0);
      waitPoll("midrst poll");
      checkSeq("midrst 900", 64'd900);
      applyStimulus(1'b0, 2'd0, 64'd0, 64'd0);
      waitIdle("midrst idle");
      checkSeq("midrst idlecmp", IDLE_CMP);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/timer_sched.md
TIMER_SCHED -- requirements
Module: timer_sched

Interface
- REQ-001 SHALL provide parameter IDLE_CMP, default 64'hFFFF_FFFF_FFFF_FFFF, the compare value programmed when no slot is armed.
- REQ-002 SHALL provide clk  in  1  system clock; all state changes on its rising edge.
- REQ-003 SHALL provide rst_n  in  1  reset, synchronous, active-low.
- REQ-004 SHALL provide cfg_valid  in  1, cfg_ready  out  1, cfg_op  in  1 (1=arm, 0=cancel), cfg_slot  in  2, cfg_deadline  in  64, cfg_period  in  64 (used only when TSCHED_PERIODIC_EN is defined).
- REQ-005 SHALL provide pend  out  4 (per-slot expired flags), pend_clr  in  4 (write-1-clear), irq  out  1 (OR of pend).
- REQ-006 SHALL provide the timer master port: t_en  out  1, t_we  out  1, t_re  out  1, t_addr  out  3, t_wdata  out  32, t_rdata  in  32. The timer uses this map: 2 = cmp_lo, 3 = cmp_hi, 4 = flag. The timer returns read data combinationally in the same cycle. Writes take effect at the next edge. The flag register is updated one edge after a compare write.

Function
- REQ-007 SHALL hold 4 slots, each with armed bit, 64-bit deadline and 64-bit period.
- REQ-008 SHALL implement FSM states IDLE, SCAN, WR_LO_MAX, WR_HI, WR_LO, SETTLE, POLL, EXPIRE.
- REQ-009 SHALL assert cfg_ready only in IDLE and POLL. A transfer occurs when cfg_valid && cfg_ready.
- REQ-010 On a transfer, arm SHALL set armed, deadline and period of cfg_slot (re-arming overwrites), and cancel SHALL clear armed. Pend is not changed by either. The next state is SCAN.
- REQ-011 SCAN SHALL select tgt, which is the minimum deadline among armed slots (ties to the lowest index), or IDLE_CMP if no slot is armed. SCAN takes 1 cycle and then goes to WR_LO_MAX.
- REQ-012 The write sequence SHALL be glitch-free:
  - WR_LO_MAX writes addr 2 = 32'hFFFF_FFFF.
  - WR_HI writes addr 3 = tgt[63:32].
  - WR_LO writes addr 2 = tgt[31:0].
  - Each write is one cycle with t_en = t_we = 1.
- REQ-013 SETTLE SHALL be one idle cycle with t_en = 0. The next state is POLL if any slot is armed, else IDLE.
- REQ-014 In POLL, SHALL drive t_en = t_re = 1 and t_addr = 4 each cycle. If t_rdata[0] == 1 and no transfer occurs that cycle, the next state is EXPIRE. A transfer takes priority over expiry.
- REQ-015 EXPIRE SHALL act on every armed slot with deadline == tgt: set pend, and clear armed (periodic behaviour per REQ-020). The next state is SCAN.
- REQ-016 When pend set and pend_clr hit the same bit in the same cycle, SHALL leave pend set.
- REQ-017 Outside write and poll cycles, SHALL hold t_en = t_we = t_re = 0 and t_addr = t_wdata = 0.
- REQ-018 Deadline comparison and arithmetic SHALL be unsigned 64-bit, and period addition SHALL wrap modulo 2^64.

Reset
- REQ-019 When rst_n = 0 at an edge, in any state including mid-write-sequence, SHALL set:
  - state = IDLE;
  - all armed = 0, deadlines = 0, periods = 0, pend = 0, tgt = IDLE_CMP;
  - cfg_ready = 1, irq = 0, and all t_* outputs = 0.
  No compare write SHALL be issued after reset until the first arm.

Configuration
- REQ-020 With macro TSCHED_PERIODIC_EN defined, SHALL handle expiring slots with nonzero period as follows: deadline += period, armed stays 1, pend is still set. A zero period behaves as one-shot.
- REQ-021 Without TSCHED_PERIODIC_EN, SHALL ignore cfg_period, omit the period storage, and treat all slots as one-shot.

Verification
- REQ-022 Reset with no traffic for 100 cycles -> t_en = 0 throughout, pend = 0, irq = 0, cfg_ready = 1.
- REQ-023 Arm slot 1, deadline 64'h1_0000_0010 -> writes in order: (2, FFFF_FFFF), (3, 0000_0001), (2, 0000_0010), then SETTLE, then POLL. Timer flag = 1 -> pend = 4'b0010, irq = 1, then an IDLE_CMP write sequence, then IDLE.
- REQ-024 Arm slot 0 @ 500 and slot 2 @ 200 -> 200 is programmed. After the flag fires, pend = 4'b0100 and 500 is programmed. The next flag -> pend = 4'b0101.
- REQ-025 Arm slot 3 @ 300, then cancel slot 3 while in POLL -> IDLE_CMP is written, pend stays 0, the FSM ends in IDLE.
- REQ-026 pend = 4'b0010, then pend_clr = 4'b0010 in the same cycle as EXPIRE on slot 1 -> pend stays 4'b0010. pend_clr alone the next cycle -> pend = 0, irq = 0.
- REQ-027 With TSCHED_PERIODIC_EN, arm slot 0 deadline 1000 period 250 -> expiries program 1250, then 1500, and slot 0 stays armed. Without the macro, the same stimulus ends with slot 0 disarmed after one expiry.
